// File: rtl/sid_envelope.sv
// sid_envelope: per-voice SID ADSR envelope generator plus two-stage VCA.
// Build option: define SID_ENV_EXP_DECAY_EN for exponential decay/release (linear otherwise).
//
//   state        | meaning
//   ST_ATTACK    | env rises by one per rate tick until 0xFF
//   ST_DECAY     | env falls toward {sustain,sustain}, then holds
//   ST_RELEASE   | env falls toward 0, then holds
module sid_envelope #(
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        CLKen,
  input  logic        WR,
  input  logic [4:0]  ADDR,
  input  logic [7:0]  DATA,
  input  logic [11:0] VOICE_IN,
  output logic [7:0]  ENV_OUT,
  output logic [11:0] OUTPUT
);

  localparam logic [4:0] ADDR_GATE = 5'(BASE_ADDR + 4);
  localparam logic [4:0] ADDR_AD   = 5'(BASE_ADDR + 5);
  localparam logic [4:0] ADDR_SR   = 5'(BASE_ADDR + 6);

  typedef enum logic [1:0] {
    ST_RELEASE = 2'd0,
    ST_ATTACK  = 2'd1,
    ST_DECAY   = 2'd2
  } state_t;

  function automatic logic [14:0] rate_period(input logic [3:0] idx);
    case (idx)
      4'd0:    rate_period = 15'd9;
      4'd1:    rate_period = 15'd32;
      4'd2:    rate_period = 15'd63;
      4'd3:    rate_period = 15'd95;
      4'd4:    rate_period = 15'd149;
      4'd5:    rate_period = 15'd220;
      4'd6:    rate_period = 15'd267;
      4'd7:    rate_period = 15'd313;
      4'd8:    rate_period = 15'd392;
      4'd9:    rate_period = 15'd977;
      4'd10:   rate_period = 15'd1954;
      4'd11:   rate_period = 15'd3126;
      4'd12:   rate_period = 15'd3907;
      4'd13:   rate_period = 15'd11720;
      4'd14:   rate_period = 15'd19532;
      default: rate_period = 15'd31251;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic        gate_q, gate_d;
  logic        gate_prev_q, gate_prev_d;
  logic [3:0]  attack_q, attack_d;
  logic [3:0]  decay_q, decay_d;
  logic [3:0]  sustain_q, sustain_d;
  logic [3:0]  release_q, release_d;
  logic [7:0]  env_q, env_d;
  logic [14:0] rate_cnt_q, rate_cnt_d;
  logic [19:0] prod_q, prod_d;
  logic [11:0] out_q, out_d;

  logic [3:0]  rate_sel;
  logic [14:0] period_m1;
  logic        rate_tick;
  logic [7:0]  target;

`ifdef SID_ENV_EXP_DECAY_EN
  logic [4:0]  exp_cnt_q, exp_cnt_d;
  logic [4:0]  exp_period_m1;

  always_comb begin
    if (env_q > 8'h5D)      exp_period_m1 = 5'd0;
    else if (env_q > 8'h36) exp_period_m1 = 5'd1;
    else if (env_q > 8'h1A) exp_period_m1 = 5'd3;
    else if (env_q > 8'h0E) exp_period_m1 = 5'd7;
    else if (env_q > 8'h06) exp_period_m1 = 5'd15;
    else                    exp_period_m1 = 5'd29;
  end
`endif

  always_comb begin
    case (state_q)
      ST_ATTACK: rate_sel = attack_q;
      ST_DECAY:  rate_sel = decay_q;
      default:   rate_sel = release_q;
    endcase
    period_m1 = rate_period(rate_sel) - 15'd1;
    rate_tick = (rate_cnt_q == period_m1);
    target    = (state_q == ST_DECAY) ? {sustain_q, sustain_q} : 8'h00;
  end

  always_comb begin
    state_d     = state_q;
    gate_d      = gate_q;
    gate_prev_d = gate_prev_q;
    attack_d    = attack_q;
    decay_d     = decay_q;
    sustain_d   = sustain_q;
    release_d   = release_q;
    env_d       = env_q;
    rate_cnt_d  = rate_cnt_q;
`ifdef SID_ENV_EXP_DECAY_EN
    exp_cnt_d   = exp_cnt_q;
`endif

    if (WR) begin
      if (ADDR == ADDR_GATE) gate_d = DATA[0];
      if (ADDR == ADDR_AD) begin
        attack_d = DATA[7:4];
        decay_d  = DATA[3:0];
      end
      if (ADDR == ADDR_SR) begin
        sustain_d = DATA[7:4];
        release_d = DATA[3:0];
      end
    end

    if (CLKen) begin
      // A lowered rate can leave the count above the new period; it then runs to the 15-bit wrap.
      rate_cnt_d  = rate_tick ? 15'd0 : rate_cnt_q + 15'd1;
      gate_prev_d = gate_q;
      if (gate_q && !gate_prev_q) begin
        state_d = ST_ATTACK;
`ifdef SID_ENV_EXP_DECAY_EN
        exp_cnt_d = 5'd0;
`endif
      end else if (!gate_q && gate_prev_q) begin
        state_d = ST_RELEASE;
      end else if (rate_tick) begin
        case (state_q)
          ST_ATTACK: begin
            if (env_q == 8'hFF) begin
              state_d = ST_DECAY;
            end else begin
              env_d = env_q + 8'd1;
              if (env_q == 8'hFE) state_d = ST_DECAY;
            end
          end
          default: begin
            if (env_q > target) begin
`ifdef SID_ENV_EXP_DECAY_EN
              if (exp_cnt_q == exp_period_m1) begin
                exp_cnt_d = 5'd0;
                env_d     = env_q - 8'd1;
              end else begin
                exp_cnt_d = exp_cnt_q + 5'd1;
              end
`else
              env_d = env_q - 8'd1;
`endif
            end
          end
        endcase
      end
    end
  end

  // VCA: recentre the waveform to signed, scale by the envelope, keep the top 12 bits.
  logic signed [11:0] voice_s;
  logic signed [8:0]  env_s;
  logic               prod_lsb_unused;

  always_comb begin
    voice_s = {~VOICE_IN[11], VOICE_IN[10:0]};
    env_s   = {1'b0, env_q};
    prod_d  = 20'(voice_s) * 20'(env_s);
    out_d   = prod_q[19:8];
  end

  assign prod_lsb_unused = ^prod_q[7:0];

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q     <= ST_RELEASE;
      gate_q      <= 1'b0;
      gate_prev_q <= 1'b0;
      attack_q    <= 4'd0;
      decay_q     <= 4'd0;
      sustain_q   <= 4'd0;
      release_q   <= 4'd0;
      env_q       <= 8'd0;
      rate_cnt_q  <= 15'd0;
      prod_q      <= 20'd0;
      out_q       <= 12'd0;
`ifdef SID_ENV_EXP_DECAY_EN
      exp_cnt_q   <= 5'd0;
`endif
    end else begin
      state_q     <= state_d;
      gate_q      <= gate_d;
      gate_prev_q <= gate_prev_d;
      attack_q    <= attack_d;
      decay_q     <= decay_d;
      sustain_q   <= sustain_d;
      release_q   <= release_d;
      env_q       <= env_d;
      rate_cnt_q  <= rate_cnt_d;
      prod_q      <= prod_d;
      out_q       <= out_d;
`ifdef SID_ENV_EXP_DECAY_EN
      exp_cnt_q   <= exp_cnt_d;
`endif
    end
  end

  assign ENV_OUT = env_q;
  assign OUTPUT  = out_q;

endmodule

// File: tb/tb_sid_envelope.sv
// tb_sid_envelope: directed ADSR/VCA scenarios plus randomized traffic, checked every cycle
// against a behavioural envelope/VCA model.
module tb_sid_envelope;

  localparam int BASE  = 7;
  localparam int M_ATT = 0;
  localparam int M_DEC = 1;
  localparam int M_REL = 2;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        CLKen = 1'b0;
  logic        WR = 1'b0;
  logic [4:0]  ADDR = '0;
  logic [7:0]  DATA = '0;
  logic [11:0] VOICE_IN = 12'h800;
  logic [7:0]  ENV_OUT;
  logic [11:0] OUTPUT;

  int n_checks = 0;
  int n_fails  = 0;

  int rate_tbl [16] = '{9, 32, 63, 95, 149, 220, 267, 313, 392, 977, 1954, 3126, 3907,
                        11720, 19532, 31251};

  // reference model state
  int m_env = 0, m_rc = 0, m_ec = 0, m_st = M_REL;
  int m_att = 0, m_dec = 0, m_sus = 0, m_rel = 0;
  int m_p = 0, m_out = 0;
  bit m_gate = 1'b0, m_gprev = 1'b0;

  sid_envelope #(.BASE_ADDR(BASE)) dut (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .CLKen    (CLKen),
    .WR       (WR),
    .ADDR     (ADDR),
    .DATA     (DATA),
    .VOICE_IN (VOICE_IN),
    .ENV_OUT  (ENV_OUT),
    .OUTPUT   (OUTPUT)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input int expv);
    n_checks++;
    if (obs !== expv) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, expv, $time);
      if (n_fails >= 50) begin
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
      end
    end
  endtask

`ifdef SID_ENV_EXP_DECAY_EN
  function automatic int exp_div(input int e);
    if (e > 'h5D) return 1;
    if (e > 'h36) return 2;
    if (e > 'h1A) return 4;
    if (e > 'h0E) return 8;
    if (e > 'h06) return 16;
    return 30;
  endfunction
`endif

  // Advances the model by one CLK edge using the inputs currently driven.
  task automatic model_step();
    int nxt_p, nxt_out, per, tgt, div;
    bit tick;
    if (!RSTn) begin
      m_env = 0; m_rc = 0; m_ec = 0; m_st = M_REL;
      m_att = 0; m_dec = 0; m_sus = 0; m_rel = 0;
      m_p = 0; m_out = 0; m_gate = 0; m_gprev = 0;
      return;
    end
    nxt_out = (m_p >>> 8) & 'hFFF;
    nxt_p   = (int'(VOICE_IN) - 2048) * m_env;
    if (CLKen) begin
      per  = (m_st == M_ATT) ? rate_tbl[m_att] : (m_st == M_DEC) ? rate_tbl[m_dec] : rate_tbl[m_rel];
      tick = (m_rc == per - 1);
      m_rc = tick ? 0 : (m_rc + 1) % 32768;
      if (m_gate && !m_gprev) begin
        m_st = M_ATT;
        m_ec = 0;
      end else if (!m_gate && m_gprev) begin
        m_st = M_REL;
      end else if (tick) begin
        if (m_st == M_ATT) begin
          if (m_env < 255) m_env++;
          if (m_env == 255) m_st = M_DEC;
        end else begin
          tgt = (m_st == M_DEC) ? m_sus * 17 : 0;
          if (m_env > tgt) begin
`ifdef SID_ENV_EXP_DECAY_EN
            div = exp_div(m_env);
`else
            div = 1;
`endif
            m_ec++;
            if (m_ec >= div) begin
              m_ec = 0;
              m_env--;
            end
          end
        end
      end
      m_gprev = m_gate;
    end
    if (WR) begin
      if (int'(ADDR) == BASE + 4) m_gate = DATA[0];
      if (int'(ADDR) == BASE + 5) begin m_att = DATA[7:4]; m_dec = DATA[3:0]; end
      if (int'(ADDR) == BASE + 6) begin m_sus = DATA[7:4]; m_rel = DATA[3:0]; end
    end
    m_p   = nxt_p;
    m_out = nxt_out;
  endtask

  task automatic clk_cycle();
    model_step();
    @(posedge CLK);
    #1;
    check_eq("env", ENV_OUT, m_env);
    check_eq("out", OUTPUT, m_out);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) clk_cycle();
  endtask

  task automatic wr_reg(input int off, input int d);
    WR   = 1'b1;
    ADDR = 5'(BASE + off);
    DATA = 8'(d);
    clk_cycle();
    WR   = 1'b0;
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    clk_cycle();
    RSTn = 1'b1;
  endtask

  task automatic wait_env(input int val, input int budget, input string tag);
    int n;
    n = 0;
    while (ENV_OUT !== 8'(val) && n < budget) begin
      clk_cycle();
      n++;
    end
    if (ENV_OUT !== 8'(val)) check_eq({tag, "_timeout"}, ENV_OUT, val);
  endtask

  initial begin
    int n, first, since, bad;
    logic [7:0] prev;
    logic [11:0] vin [3];
    int vexp [3];
    int prev_exp;

    // reset state
    CLKen = 1'b1;
    RSTn  = 1'b0;
    run(2);
    check_eq("rst_env", ENV_OUT, 0);
    check_eq("rst_out", OUTPUT, 0);
    RSTn = 1'b1;

    // reset in mid-attack
    VOICE_IN = 12'hFFF;
    wr_reg(6, 'hF0);
    wr_reg(5, 'h00);
    wr_reg(4, 1);
    wait_env('h40, 1000, "rst_mid_reach");
    do_reset();
    check_eq("rst_mid_env", ENV_OUT, 0);
    run(2);
    check_eq("rst_mid_out", OUTPUT, 0);
    run(100);
    check_eq("rst_stays_release", ENV_OUT, 0);

    // attack: one step every 9 ticks, 254 steps from 0x01 to 0xFF, then holds
    VOICE_IN = 12'h800;
    wr_reg(6, 'hF0);
    wr_reg(5, 'h00);
    wr_reg(4, 1);
    prev = ENV_OUT; since = 0; first = -1; bad = 0; n = 0;
    while (ENV_OUT !== 8'hFF && n < 4000) begin
      clk_cycle();
      n++;
      since++;
      if (ENV_OUT !== prev) begin
        if (first < 0) first = n;
        else if (since != 9) bad++;
        since = 0;
        prev  = ENV_OUT;
      end
    end
    check_eq("atk_reach_ff", ENV_OUT, 'hFF);
    check_eq("atk_irregular_steps", bad, 0);
    check_eq("atk_ticks_01_to_ff", n - first, 254 * 9);
    run(300);
    check_eq("atk_hold_ff", ENV_OUT, 'hFF);

    // decay to sustain 0x88
    wr_reg(6, 'h80);
    wait_env('h88, 3000, "dec_reach");
    run(1000);
    check_eq("dec_holds_88", ENV_OUT, 'h88);

    // release to zero; step interval at 0x50
    wr_reg(4, 0);
    wait_env('h50, 8000, "rel_reach_50");
    n = 0;
    while (ENV_OUT === 8'h50 && n < 100) begin
      clk_cycle();
      n++;
    end
`ifdef SID_ENV_EXP_DECAY_EN
    check_eq("rel_step_at_50", n, 18);
`else
    check_eq("rel_step_at_50", n, 9);
`endif
    check_eq("rel_next_val", ENV_OUT, 'h4F);
    wait_env(0, 10000, "rel_reach_0");
    run(10000);
    check_eq("rel_hold_zero", ENV_OUT, 0);

    // VCA at full envelope
    do_reset();
    VOICE_IN = 12'h800;
    wr_reg(6, 'hF0);
    wr_reg(5, 'h00);
    wr_reg(4, 1);
    wait_env('hFF, 4000, "vca_env_ff");
    run(3);
    vin[0] = 12'hFFF; vin[1] = 12'h000; vin[2] = 12'h800;
    vexp[0] = 'h7F7;  vexp[1] = 'h808;  vexp[2] = 'h000;
    prev_exp = 0;
    for (int i = 0; i < 3; i++) begin
      VOICE_IN = vin[i];
      clk_cycle();
      check_eq("vca_latency_hold", OUTPUT, prev_exp);
      clk_cycle();
      check_eq("vca_out", OUTPUT, vexp[i]);
      prev_exp = vexp[i];
    end

    // rate counter overshoot after lowering the attack rate
    do_reset();
    wr_reg(5, 'hF0);
    wr_reg(4, 1);
    n = 0;
    while (m_rc != 1000 && n < 2000) begin
      clk_cycle();
      n++;
    end
    if (m_rc != 1000) check_eq("wrap_setup_timeout", m_rc, 1000);
    wr_reg(5, 'h00);
    n = 0;
    while (ENV_OUT === 8'h00 && n < 40000) begin
      clk_cycle();
      n++;
    end
    check_eq("wrap_first_step", n, 31776);
    check_eq("wrap_step_val", ENV_OUT, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      CLKen    = ($urandom_range(0, 3) != 0);
      VOICE_IN = 12'($urandom);
      RSTn     = ($urandom_range(0, 999) != 0);
      if ($urandom_range(0, 7) == 0) begin
        WR   = 1'b1;
        ADDR = 5'($urandom_range(BASE, BASE + 6));
        DATA = 8'($urandom) & 8'h31;
      end
      clk_cycle();
      WR   = 1'b0;
      RSTn = 1'b1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/sid_envelope.md
Name: sid_envelope

Overview:
- Per-voice ADSR envelope generator and VCA, directly downstream of the voice oscillator/waveform stage.
- Decodes the gate, attack/decay and sustain/release registers from the shared SID register bus.
- Steps an 8-bit envelope at 1 MHz CLKen rate, then scales the voice's unsigned 12-bit waveform into a signed 12-bit sample for the mixer/filter.

Parameters:
BASE_ADDR, 0, register offset of the owning voice (gate at +4, AD at +5, SR at +6)

Ports:
CLK  input  1  master clock
RSTn  input  1  synchronous active-low reset
CLKen  input  1  1 MHz tick enable
WR  input  1  register write strobe
ADDR  input  5  register address
DATA  input  8  write data
VOICE_IN  input  12  voice waveform, unsigned, centre 0x800
ENV_OUT  output  8  current envelope level
OUTPUT  output  12  signed two's-complement enveloped sample

Behaviour:
- Reset: one clock (CLK), synchronous, active-low reset RSTn; all state updates on posedge CLK. RSTn low at an edge clears all state at that edge, including mid-attack or mid-release. Reset values: gate=0, attack/decay/sustain/release=0, state=RELEASE, env=0, rate_cnt=0, exp_cnt=0, ENV_OUT=0, OUTPUT=0, pipeline regs=0.
- Register writes (WR, any cycle, independent of CLKen):
  - BASE+4: gate<=DATA[0]; other bits ignored here.
  - BASE+5: attack<=DATA[7:4], decay<=DATA[3:0].
  - BASE+6: sustain<=DATA[7:4], release<=DATA[3:0].
- Rate period table, in CLKen ticks, indexed 0..15: 9, 32, 63, 95, 149, 220, 267, 313, 392, 977, 1954, 3126, 3907, 11720, 19532, 31251. The period used is selected by the current state's nibble.
- rate_cnt: 15-bit, increments on each CLKen.
  - A rate tick occurs when rate_cnt == period-1; rate_cnt then <=0.
  - Otherwise it wraps 0x7FFF->0.
  - Consequence: lowering the rate below the current count delays the next tick until after the wrap.
- Gate edges: gate is sampled on each CLKen against gate_prev.
  - Rising edge: state<=ATTACK, exp_cnt<=0.
  - Falling edge: state<=RELEASE.
  - rate_cnt is never reset by a gate edge.
  - In a CLKen cycle with a gate edge, no env step occurs.
- ATTACK: each rate tick, env<=env+1. When env reaches 0xFF, state<=DECAY_SUSTAIN. Attack ignores exp_cnt.
- DECAY_SUSTAIN: target = {sustain,sustain} (e.g. 0x8 -> 0x88).
  - On a rate tick: if env > target, exp_cnt increments.
  - When exp_cnt reaches exp_period-1: exp_cnt<=0 and env<=env-1.
  - env <= target: hold. Env never rises in this state.
- RELEASE: same exponential stepping as DECAY_SUSTAIN, with floor 0. Env holds at 0 with no wrap.
- exp_period from current env: >0x5D:1, >0x36:2, >0x1A:4, >0x0E:8, >0x06:16, else 30.
- ENV_OUT = env register; it changes on the same CLK edge as the step.
- VCA, free-running on CLK (not CLKen):
  - Stage 1: s = {~VOICE_IN[11], VOICE_IN[10:0]} as signed 12-bit; p = s * {0,env}, 20-bit signed, registered.
  - Stage 2: OUTPUT <= p[19:8] (arithmetic truncation toward -inf).
  - Latency: 2 CLK cycles from VOICE_IN/env change to OUTPUT.
- env=0 gives OUTPUT=0 regardless of VOICE_IN.

Optional Feature:
- Macro: SID_ENV_EXP_DECAY_EN.
- Defined: exponential decay/release as above.
- Undefined: exp_period fixed at 1; decay and release are linear, stepping one per rate tick; the exp_cnt logic is removed.
- Attack is identical in both builds.

Test Plan:
- Reset: RSTn=0 for one edge during attack at env=0x40 -> ENV_OUT=0x00, state RELEASE, OUTPUT=0x000 after 2 CLKs.
- Attack: AD=0x00, SR=0xF0, gate 0->1 -> ENV_OUT +1 every 9 CLKen ticks; 0xFF after 2295 ticks; holds 0xFF (sustain 0xFF), no wrap.
- Decay/sustain: AD=0x00, SR=0x80, gate on -> env rises to 0xFF, then falls and stops at exactly 0x88; with macro, the step interval at env 0x50 is 18 ticks (rate 9 x exp 2).
- Release: env at 0x88, release=0, gate 1->0 -> env decrements to 0x00 and holds 0x00 for 10000 ticks.
- VCA: env held 0xFF; VOICE_IN=0xFFF -> OUTPUT=0x7F7; VOICE_IN=0x000 -> OUTPUT=0x808; VOICE_IN=0x800 -> 0x000; each 2 CLKs after the input change.
- Rate-counter wrap: attack=15, gate on, rate_cnt=1000; write AD=0x00 -> no step until rate_cnt wraps; next step 31776 CLKen ticks after the write.
